message_ctrl: RTL

Parametrised on-screen message controller that generalises the single game-over latch to NUM_MSG prioritised messages. It handles timed (auto-expiring) and sticky (held until restart) messages. It sits between game-logic event sources (level complete, life lost, game over, win) and the message drawing objects. It drives one-hot drawing requests and a game-freeze flag to the game controller.

---
 rtl/msg_pkg.sv | 21 ++
 rtl/msg_prio_enc.sv | 27 ++
 rtl/message_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/msg_pkg.sv
// msg_pkg: shared definitions for the on-screen message controller.
//   - msgState_t : controller state encoding
//   - MSG_*      : message channel indices (higher index = higher priority)
//   - DEFAULT_STICKY_MASK : channels that latch until restart
package msg_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHOW    = 2'd1,
    S_LATCHED = 2'd2
  } msgState_t;

  localparam int MSG_LEVEL_DONE = 0;
  localparam int MSG_LIFE_LOST  = 1;
  localparam int MSG_WIN        = 2;
  localparam int MSG_GAME_OVER  = 3;

  // Only game-over is sticky by default.
  localparam logic [3:0] DEFAULT_STICKY_MASK = 4'b1000;

endpackage

// File: rtl/msg_prio_enc.sv
// msg_prio_enc: highest-set-bit priority encoder.
// Ports:
//   req   in  N     request vector
//   valid out 1     any request bit set
//   idx   out IDW   index of the highest set bit (0 when nothing is set)
module msg_prio_enc #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  // Ascending scan: the last (highest) set bit seen overwrites the result.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/message_ctrl.sv
// message_ctrl: prioritised on-screen message controller.
// Timed messages expire after HOLD_FRAMES startOfFrame pulses; sticky
// messages (STICKY_MASK) stay up and freeze the game until restart.
// Ports:
//   clk          in  1        system clock
//   resetN       in  1        asynchronous active-low reset
//   startOfFrame in  1        one-cycle pulse per frame (timer time-base)
//   msg_req      in  NUM_MSG  per-message request, level or pulse
//   restart      in  1        clears any shown message
//   msg_DR       out NUM_MSG  one-hot drawing request of the shown message
//   msg_active   out 1        a message is shown
//   msg_id       out IDW      index of the shown message, 0 when idle
//   freeze       out 1        a sticky message is shown
module message_ctrl
  import msg_pkg::*;
#(
  parameter int                   NUM_MSG     = 4,
  parameter int                   HOLD_FRAMES = 120,
  parameter logic [NUM_MSG-1:0]   STICKY_MASK = DEFAULT_STICKY_MASK,
  parameter int                   IDW         = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_MSG-1:0] msg_req,
  input  logic               restart,
  output logic [NUM_MSG-1:0] msg_DR,
  output logic               msg_active,
  output logic [IDW-1:0]     msg_id,
  output logic               freeze
);

  localparam int TW = $clog2(HOLD_FRAMES + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_FRAMES);

  msgState_t      stateReg, stateNext;
  logic [IDW-1:0] idReg, idNext;
  logic [TW-1:0]  timerReg, timerNext;

  logic           reqValid;
  logic [IDW-1:0] winIdx;

  msg_prio_enc #(
    .N   (NUM_MSG),
    .IDW (IDW)
  ) uPrioEnc (
    .req   (msg_req),
    .valid (reqValid),
    .idx   (winIdx)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateReg <= S_IDLE;
      idReg    <= '0;
      timerReg <= '0;
    end else begin
      stateReg <= stateNext;
      idReg    <= idNext;
      timerReg <= timerNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    idNext    = idReg;
    timerNext = timerReg;

    if (restart) begin
      // Restart beats any same-cycle request.
      stateNext = S_IDLE;
      idNext    = '0;
      timerNext = '0;
    end else begin
      unique case (stateReg)
        S_IDLE: begin
          if (reqValid) begin
            stateNext = STICKY_MASK[winIdx] ? S_LATCHED : S_SHOW;
            idNext    = winIdx;
            timerNext = HOLD_LOAD;
          end
        end

        S_SHOW: begin
          // Preempt (higher) or re-trigger (same) wins over a same-cycle
          // expiry, so a held level keeps the message up without a gap.
          if (reqValid && (winIdx >= idReg)) begin
            stateNext = STICKY_MASK[winIdx] ? S_LATCHED : S_SHOW;
            idNext    = winIdx;
            timerNext = HOLD_LOAD;
          end else if (startOfFrame) begin
            if (timerReg == TW'(1)) begin
              stateNext = S_IDLE;
              idNext    = '0;
              timerNext = '0;
            end else if (timerReg != '0) begin
              timerNext = timerReg - TW'(1);
            end
          end
        end

        S_LATCHED: begin
          // Held until restart; requests and frames are ignored.
        end

        default: begin
          stateNext = S_IDLE;
          idNext    = '0;
          timerNext = '0;
        end
      endcase
    end
  end

  // idReg is forced to 0 whenever the controller goes idle, so it can be
  // driven out directly.
  assign msg_id     = idReg;
  assign msg_active = (stateReg != S_IDLE);
  assign freeze     = (stateReg == S_LATCHED);
  assign msg_DR     = msg_active ? (NUM_MSG'(1) << idReg) : '0;

endmodule
